// File: rtl/axis_dac_spi_tx.sv
// Four-channel AXI-Stream to quad serial DAC transmitter: sends a control frame after reset,
// then one 24-bit frame per channel in lockstep for each joint four-way handshake, followed by an LDAC pulse.
`timescale 1ns/1ps
module axis_dac_spi_tx #(
  parameter int                  SAXIS_TDATA_WIDTH = 32,
  parameter int                  DAC_BITS          = 20,
  parameter int                  SCLK_DIV          = 2,
  parameter int                  GAP_CYCLES        = 4,
  parameter int                  LDAC_CYCLES       = 2,
  parameter logic [DAC_BITS+3:0] CTRL_WORD         = 24'h200012
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS1_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS2_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS3_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS4_tdata,
  input  logic                         S_AXIS1_tvalid,
  input  logic                         S_AXIS2_tvalid,
  input  logic                         S_AXIS3_tvalid,
  input  logic                         S_AXIS4_tvalid,
  output logic                         S_AXIS1_tready,
  output logic                         S_AXIS2_tready,
  output logic                         S_AXIS3_tready,
  output logic                         S_AXIS4_tready,
  input  logic                         enable,
  output logic                         dac_sclk,
  output logic                         dac_sync_n,
  output logic [3:0]                   dac_sdi,
  output logic                         dac_ldac_n,
  output logic                         busy,
  output logic [31:0]                  frame_count
);

  localparam int FW       = DAC_BITS + 4;
  localparam int PH_W     = $clog2(2 * SCLK_DIV + 1);
  localparam int BIT_W    = $clog2(FW + 1);
  localparam int WAIT_MAX = (GAP_CYCLES > LDAC_CYCLES) ? GAP_CYCLES : LDAC_CYCLES;
  localparam int WT_W     = $clog2(WAIT_MAX + 1);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * SCLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(SCLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FW - 1);
  localparam logic [WT_W-1:0]  GAP_LAST  = WT_W'(GAP_CYCLES - 1);
  localparam logic [WT_W-1:0]  LDAC_LAST = WT_W'(LDAC_CYCLES - 1);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_LDAC  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WT_W-1:0]  wt_q, wt_d;
  logic             is_data_q, is_data_d;
  logic [31:0]      fc_q, fc_d;
  logic [FW-1:0]    sr_q [4];
  logic [FW-1:0]    sr_d [4];

  logic [SAXIS_TDATA_WIDTH-1:0] tdata_w [4];
  logic [FW-1:0]                frame_w [4];
  logic [3:0]                   tvalid_w;
  logic                         handshake_w;

  assign tdata_w[0] = S_AXIS1_tdata;
  assign tdata_w[1] = S_AXIS2_tdata;
  assign tdata_w[2] = S_AXIS3_tdata;
  assign tdata_w[3] = S_AXIS4_tdata;
  assign tvalid_w   = {S_AXIS4_tvalid, S_AXIS3_tvalid, S_AXIS2_tvalid, S_AXIS1_tvalid};

  // All four streams are consumed together or not at all.
  assign handshake_w    = (state_q == ST_IDLE) && enable && (&tvalid_w);
  assign S_AXIS1_tready = handshake_w;
  assign S_AXIS2_tready = handshake_w;
  assign S_AXIS3_tready = handshake_w;
  assign S_AXIS4_tready = handshake_w;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      // DAC code is the sample MSBs, truncated; low bits are deliberately dropped.
      assign frame_w[gi] = {4'b0001, tdata_w[gi][SAXIS_TDATA_WIDTH-1 -: DAC_BITS]};
      assign dac_sdi[gi] = (state_q == ST_SHIFT) ? sr_q[gi][FW-1] : 1'b0;

      if (SAXIS_TDATA_WIDTH > DAC_BITS) begin : g_lsb
        logic unused_lsbs;
        assign unused_lsbs = ^tdata_w[gi][SAXIS_TDATA_WIDTH-DAC_BITS-1:0];
      end

      always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
          sr_q[gi] <= '0;
        end else begin
          sr_q[gi] <= sr_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    wt_d      = wt_q;
    is_data_d = is_data_q;
    fc_d      = fc_q;
    for (int k = 0; k < 4; k++) begin
      sr_d[k] = sr_q[k];
    end
    case (state_q)
      ST_INIT: begin
        for (int k = 0; k < 4; k++) begin
          sr_d[k] = CTRL_WORD;
        end
        is_data_d = 1'b0;
        ph_d      = '0;
        bit_d     = '0;
        state_d   = ST_SHIFT;
      end
      ST_IDLE: begin
        if (handshake_w) begin
          for (int k = 0; k < 4; k++) begin
            sr_d[k] = frame_w[k];
          end
          is_data_d = 1'b1;
          ph_d      = '0;
          bit_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          for (int k = 0; k < 4; k++) begin
            sr_d[k] = {sr_q[k][FW-2:0], 1'b0};
          end
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            wt_d    = '0;
            state_d = ST_GAP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_GAP: begin
        if (wt_q == GAP_LAST) begin
          wt_d    = '0;
          state_d = is_data_q ? ST_LDAC : ST_IDLE;
        end else begin
          wt_d = wt_q + WT_W'(1);
        end
      end
      ST_LDAC: begin
        if (wt_q == LDAC_LAST) begin
          wt_d    = '0;
          fc_d    = fc_q + 32'd1;
          state_d = ST_IDLE;
        end else begin
          wt_d = wt_q + WT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q   <= ST_INIT;
      ph_q      <= '0;
      bit_q     <= '0;
      wt_q      <= '0;
      is_data_q <= 1'b0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      wt_q      <= wt_d;
      is_data_q <= is_data_d;
      fc_q      <= fc_d;
    end
  end

  // Pin values are decoded from state so reset forces them without waiting for a clock.
  assign dac_sync_n  = (state_q != ST_SHIFT);
  assign dac_sclk    = (state_q == ST_SHIFT) && (ph_q < PH_HIGH);
  assign dac_ldac_n  = (state_q != ST_LDAC);
  assign busy        = (state_q != ST_IDLE);
  assign frame_count = fc_q;

endmodule
